// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single byte-wide RAM/IO bus between the instruction-fetch port
// (always 4-byte reads) and the load/store port (1/2/4-byte reads and writes).
// A granted access is issued as consecutive byte transactions. Read bytes are
// assembled little-endian, and a one-cycle ready pulse goes back to the owner.
//
// Ports
//   clk_in, rst_in      clock, asynchronous active-low reset
//   rdy_in              global enable; low freezes every register
//   mem_din             read byte, valid the cycle after its address is driven
//   mem_dout/mem_a/mem_wr  registered byte bus toward RAM/IO
//   io_buffer_full      UART tx buffer full; stalls IO-region stores
//   flush               RoB clear; aborts in-flight reads and blocks accepts
//   i_req/i_addr        fetch request (held until i_ready)
//   i_ready/i_data      fetch done pulse and fetched word
//   d_req/d_wr/d_addr/d_len/d_wdata  load/store request (held until d_ready)
//   d_ready/d_rdata     load/store done pulse and zero-extended load data
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int IO_MASK_HI = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,

  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,

  input  logic              flush,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_data,

  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_len,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_WAIT_IO = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base;      // start address of the granted access
  logic [2:0]        len;       // byte count of the granted access
  logic [31:0]       wdata;     // latched store data
  logic              owner_d;   // 1 = load/store port owns the bus
  // Number of clock edges seen since the accept edge. In READ this value
  // selects both the next address offset and (minus two) the byte being
  // captured, since a byte arrives two edges after its address is issued.
  logic [3:0]        cnt;
  logic [31:0]       rbuf;      // partially assembled read word

  logic [3:0]        len_ext;
  logic [ADDR_W-1:0] addr_k;
  logic [7:0]        wbyte_k;
  logic [1:0]        cap_idx;
  logic [31:0]       rbuf_next;
  logic [31:0]       rbuf_done;
  logic              io_hit;
  logic              accept_d;
  logic              accept_i;

  assign len_ext = {1'b0, len};
  assign addr_k  = base + ADDR_W'(cnt);   // wraps modulo 2^ADDR_W
  assign wbyte_k = wdata[{cnt[1:0], 3'b000} +: 8];
  assign cap_idx = cnt[1:0] - 2'd2;
  assign io_hit  = (d_addr[IO_MASK_HI -: 2] == 2'b11);

  // A requester still holds its req during its own ready-pulse cycle, so it
  // must not be re-granted on that edge. The other port may be granted then,
  // which gives back-to-back service with a single IDLE cycle between owners.
  assign accept_d = d_req && !d_ready && !flush;
  assign accept_i = i_req && !i_ready && !flush && !accept_d;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  // The final byte is merged as it is returned so the word and the ready pulse
  // become valid together. Bytes beyond the length were cleared at accept time,
  // which gives the zero extension of short loads.
  assign rbuf_done = (cnt >= 4'd2) ? rbuf_next : rbuf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      base     <= '0;
      len      <= '0;
      wdata    <= '0;
      owner_d  <= 1'b0;
      cnt      <= '0;
      rbuf     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      i_data   <= '0;
      d_rdata  <= '0;
    end else if (rdy_in) begin
      // Ready outputs are single-cycle pulses unless re-asserted below.
      i_ready <= 1'b0;
      d_ready <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept_d) begin
            base    <= d_addr;
            len     <= d_len;
            wdata   <= d_wdata;
            owner_d <= 1'b1;
            rbuf    <= '0;
            cnt     <= 4'd1;
            if (d_wr) begin
              if (io_hit && io_buffer_full) begin
                // Hold the store off the bus until the UART can take it.
                state  <= ST_WAIT_IO;
                mem_wr <= 1'b0;
              end else begin
                state    <= ST_WRITE;
                mem_a    <= d_addr;
                mem_dout <= d_wdata[7:0];
                mem_wr   <= 1'b1;
              end
            end else begin
              state  <= ST_READ;
              mem_a  <= d_addr;
              mem_wr <= 1'b0;
            end
          end else if (accept_i) begin
            base    <= i_addr;
            len     <= 3'd4;
            owner_d <= 1'b0;
            rbuf    <= '0;
            cnt     <= 4'd1;
            state   <= ST_READ;
            mem_a   <= i_addr;
            mem_wr  <= 1'b0;
          end
        end

        ST_WAIT_IO: begin
          // Stores are already committed, so flush is not honoured here.
          mem_wr <= 1'b0;
          if (!io_buffer_full) begin
            state    <= ST_WRITE;
            mem_a    <= base;
            mem_dout <= wdata[7:0];
            mem_wr   <= 1'b1;
            cnt      <= 4'd1;
          end
        end

        ST_WRITE: begin
          // One byte per cycle with no wait; flush is not honoured here either.
          if (cnt < len_ext) begin
            mem_a    <= addr_k;
            mem_dout <= wbyte_k;
            mem_wr   <= 1'b1;
            cnt      <= cnt + 4'd1;
          end else begin
            mem_wr  <= 1'b0;
            mem_a   <= '0;
            d_ready <= 1'b1;
            cnt     <= '0;
            state   <= ST_IDLE;
          end
        end

        ST_READ: begin
          if (flush) begin
            // Speculative read: drop it, discard partial data, no ready pulse.
            state  <= ST_IDLE;
            mem_wr <= 1'b0;
            cnt    <= '0;
          end else begin
            if (cnt < len_ext) begin
              mem_a <= addr_k;
            end
            if (cnt >= 4'd2) begin
              rbuf <= rbuf_next;
            end
            if (cnt >= len_ext + 4'd1) begin
              state <= ST_IDLE;
              cnt   <= '0;
              if (owner_d) begin
                d_ready <= 1'b1;
                d_rdata <= rbuf_done;
              end else begin
                i_ready <= 1'b1;
                i_data  <= rbuf_done;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          mem_wr <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A byte memory model answers reads one
// cycle after the address and logs writes. Expected ready events and expected
// bus writes are queued when a request is driven and compared by monitors as
// the DUT produces them. Directed scenarios: fetch, arbitration, stores, IO
// stall, flush, rdy_in pause and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        flush;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_data;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [2:0]  d_len;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  mem_arbiter #(.ADDR_W(32), .IO_MASK_HI(17)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .flush          (flush),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_ready        (i_ready),
    .i_data         (i_data),
    .d_req          (d_req),
    .d_wr           (d_wr),
    .d_addr         (d_addr),
    .d_len          (d_len),
    .d_wdata        (d_wdata),
    .d_ready        (d_ready),
    .d_rdata        (d_rdata)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  bit [7:0] mem [bit [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = rd(a + 32'(k));
    return w;
  endfunction

  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= rd(mem_a);
  end

  // ---------------- scoreboards ----------------
  typedef struct {
    bit          owner_d;
    bit          chk;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      wr_count = 0;

  always @(negedge clk_in) begin
    if (rst_in && (i_ready || d_ready)) begin
      rd_exp_t e;
      check("ready_excl", 32'(i_ready & d_ready), 32'd0);
      if (rd_q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = rd_q.pop_front();
        check("ready_owner", 32'(d_ready), 32'(e.owner_d));
        if (e.chk) check("ready_data", d_ready ? d_rdata : i_data, e.data);
      end
    end
    if (rst_in && rdy_in && mem_wr) begin
      wr_exp_t w;
      wr_count++;
      if (mem_a[17:16] == 2'b11 && io_buffer_full)
        check("io_write_while_full", 32'd1, 32'd0);
      if (wr_q.size() == 0) begin
        check("spurious_write", {24'd0, mem_dout}, 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("write_addr", mem_a, w.a);
        check("write_data", {24'd0, mem_dout}, {24'd0, w.d});
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_read(input bit owner_d, input logic [31:0] a, input int n);
    rd_exp_t e;
    e.owner_d = owner_d;
    e.chk     = 1'b1;
    e.data    = exp_word(a, n);
    rd_q.push_back(e);
  endtask

  task automatic push_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    rd_exp_t e;
    wr_exp_t w;
    for (int k = 0; k < n; k++) begin
      w.a = a + 32'(k);
      w.d = wd[8*k +: 8];
      wr_q.push_back(w);
    end
    e.owner_d = 1'b1;
    e.chk     = 1'b0;
    e.data    = '0;
    rd_q.push_back(e);
  endtask

  // Waits for the selected ready; lat is the index of the edge (0 = first edge
  // after the call) after which it was seen. The request is dropped on return.
  task automatic wait_ready(input bit dsel, input int budget, output int lat);
    lat = -1;
    for (int e = 0; e < budget; e++) begin
      tick();
      if (dsel ? d_ready : i_ready) begin
        lat = e;
        break;
      end
    end
    if (lat < 0) check(dsel ? "timeout_d_ready" : "timeout_i_ready", 32'd0, 32'd1);
    if (dsel) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_a"},    mem_a,             32'd0);
    check({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
    check({tag, "_mem_wr"},   32'(mem_wr),       32'd0);
    check({tag, "_i_ready"},  32'(i_ready),      32'd0);
    check({tag, "_d_ready"},  32'(d_ready),      32'd0);
    check({tag, "_i_data"},   i_data,            32'd0);
    check({tag, "_d_rdata"},  d_rdata,           32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;

    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0;
    d_len = 3'd0; d_wdata = '0;

    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h10; mem[32'h103] = 8'h00;
    mem[32'h204] = 8'hAA; mem[32'h205] = 8'hBB; mem[32'h206] = 8'hCC;
    mem[32'h400] = 8'h93; mem[32'h401] = 8'h80; mem[32'h402] = 8'h10; mem[32'h403] = 8'h00;
    mem[32'h500] = 8'h01; mem[32'h501] = 8'h02; mem[32'h502] = 8'h03; mem[32'h503] = 8'h04;
    mem[32'h600] = 8'h11; mem[32'h601] = 8'h22; mem[32'h602] = 8'h33; mem[32'h603] = 8'h44;

    tick(); tick();
    check_reset_outputs("reset");
    rst_in = 1'b1;
    tick();

    // Fetch alone: consecutive byte addresses, i_ready after E5.
    push_read(1'b0, 32'h100, 4);
    i_addr = 32'h100;
    i_req  = 1'b1;
    lat    = -1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (e < 4) begin
        check("fetch_mem_a", mem_a, 32'h100 + 32'(e));
        check("fetch_mem_wr", 32'(mem_wr), 32'd0);
      end
      if (i_ready) begin
        lat = e;
        break;
      end
    end
    i_req = 1'b0;
    check("fetch_lat", 32'(lat), 32'd5);
    check("fetch_word", i_data, 32'h00100513);
    tick();

    // Simultaneous requests: load served first, fetch on the edge after d_ready.
    push_read(1'b1, 32'h204, 2);
    push_read(1'b0, 32'h500, 4);
    d_wr = 1'b0; d_addr = 32'h204; d_len = 3'd2;
    i_addr = 32'h500;
    d_req = 1'b1; i_req = 1'b1;
    wait_ready(1'b1, 20, lat);
    check("load2_lat", 32'(lat), 32'd3);
    check("load2_data", d_rdata, 32'h0000BBAA);
    wait_ready(1'b0, 20, lat);
    check("fetch_after_load_lat", 32'(lat), 32'd5);
    tick();

    // Store of four bytes, d_ready after E4, bus released.
    push_store(32'h300, 4, 32'hDEADBEEF);
    d_wr = 1'b1; d_addr = 32'h300; d_len = 3'd4; d_wdata = 32'hDEADBEEF;
    d_req = 1'b1;
    wait_ready(1'b1, 20, lat);
    check("store4_lat", 32'(lat), 32'd4);
    check("store4_wr_off", 32'(mem_wr), 32'd0);
    check("store4_a_off", mem_a, 32'd0);
    d_wr = 1'b0;
    tick();
    check("store4_wr_idle", 32'(mem_wr), 32'd0);

    // IO store held off while the UART buffer is full.
    lat = wr_count;
    push_store(32'h30000, 1, 32'h00000041);
    io_buffer_full = 1'b1;
    d_wr = 1'b1; d_addr = 32'h30000; d_len = 3'd1; d_wdata = 32'h00000041;
    d_req = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      check("io_wait_wr", 32'(mem_wr), 32'd0);
    end
    io_buffer_full = 1'b0;
    begin
      int base_wr;
      base_wr = lat;
      wait_ready(1'b1, 10, lat);
      check("io_release_lat", 32'(lat), 32'd1);
      tick();
      check("io_write_count", 32'(wr_count - base_wr), 32'd1);
    end
    d_wr = 1'b0;

    // Flush at E2 of a fetch aborts it; a new fetch is accepted at E3.
    i_addr = 32'h100;
    i_req  = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_wr", 32'(mem_wr), 32'd0);
    push_read(1'b0, 32'h400, 4);
    i_addr = 32'h400;
    wait_ready(1'b0, 20, lat);
    check("post_flush_fetch_lat", 32'(lat), 32'd5);
    check("post_flush_fetch_word", i_data, 32'h00108093);
    tick();

    // Flush during a store is ignored; the store completes.
    push_store(32'h310, 2, 32'h00001234);
    d_wr = 1'b1; d_addr = 32'h310; d_len = 3'd2; d_wdata = 32'h00001234;
    d_req = 1'b1;
    tick();
    flush = 1'b1;
    wait_ready(1'b1, 10, lat);
    flush = 1'b0;
    check("flush_store_lat", 32'(lat), 32'd1);
    d_wr = 1'b0;
    tick();

    // Load reference run, then the same load with rdy_in low for 5 cycles.
    push_read(1'b1, 32'h600, 4);
    d_addr = 32'h600; d_len = 3'd4;
    d_req = 1'b1;
    wait_ready(1'b1, 20, lat);
    check("load4_lat", 32'(lat), 32'd5);
    tick();
    push_read(1'b1, 32'h600, 4);
    d_req = 1'b1;
    tick(); tick(); tick();
    check("pause_mem_a_before", mem_a, 32'h602);
    rdy_in = 1'b0;
    repeat (5) tick();
    check("pause_mem_a_frozen", mem_a, 32'h602);
    check("pause_no_ready", 32'(d_ready), 32'd0);
    rdy_in = 1'b1;
    wait_ready(1'b1, 20, lat);
    check("pause_resume_lat", 32'(lat), 32'd2);
    check("pause_load_data", d_rdata, 32'h44332211);
    tick();

    // Asynchronous reset in the middle of a fetch.
    i_addr = 32'h100;
    i_req  = 1'b1;
    tick(); tick(); tick();
    rst_in = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    i_req = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
    tick();
    push_read(1'b0, 32'h400, 4);
    i_addr = 32'h400;
    i_req  = 1'b1;
    wait_ready(1'b0, 20, lat);
    check("post_reset_fetch_lat", 32'(lat), 32'd5);
    repeat (4) tick();

    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM/IO bus and shares it between two requesters: the instruction-fetch port (4-byte reads) and the load/store port (1/2/4-byte reads and writes).
- Each granted word access is broken into sequential byte transactions; the block assembles read bytes little-endian and returns a one-cycle done pulse.
- Sits between the fetch unit/LSB and the top-level mem_* pins, and honours the RoB flush.

Parameters:
ADDR_W, 32, width of mem_a and request addresses
IO_MASK_HI, 17, upper bit of the IO-region test (IO region when addr[17:16]==2'b11)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global enable; when low, every register holds its value
mem_din  input  8  read byte; valid the cycle after its address is driven
mem_dout  output  8  write byte
mem_a  output  32  byte address
mem_wr  output  1  1 = write
io_buffer_full  input  1  UART tx buffer full
flush  input  1  RoB clear; aborts speculative traffic
i_req  input  1  fetch request, held high until i_ready
i_addr  input  32  fetch address (4 bytes)
i_ready  output  1  one-cycle pulse; i_data is valid
i_data  output  32  fetched word
d_req  input  1  data request, held high until d_ready
d_wr  input  1  1 = store
d_addr  input  32  data address
d_len  input  3  byte count: 1, 2 or 4
d_wdata  input  32  store data; byte k = d_wdata[8k+7:8k]
d_ready  output  1  one-cycle pulse; load/store done
d_rdata  output  32  load data, zero-extended, byte 0 in [7:0]

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, i_ready=0, d_ready=0, i_data=0, d_rdata=0, byte counter=0.
- All outputs are registered.
- States: IDLE, READ, WRITE, WAIT_IO.
- IDLE arbitration, sampled at edge E0:
  - d_req has priority over i_req.
  - A request is not accepted on the edge where its ready pulse is asserted.
  - A request is not accepted while flush=1.
  - On accept, latch the address, length (4 for fetch), write data and owner.
  - Next state: READ; WRITE if d_wr=1; WAIT_IO if d_wr=1, the address is in the IO region and io_buffer_full=1.
- WAIT_IO:
  - mem_wr=0; hold here while io_buffer_full=1.
  - When it drops, go to WRITE at the following edge.
- READ, N bytes:
  - Address base+k is driven on mem_a in the cycle after edge Ek, for k=0..N-1, with mem_wr=0.
  - mem_din is captured into byte k at edge E(k+2).
  - At edge E(N+1), the owner's ready goes to 1 for exactly one cycle, data becomes valid, and state returns to IDLE.
  - Fetch: accept E0, i_ready high after E5.
  - Unused upper bytes of d_rdata are 0.
- WRITE, N bytes:
  - mem_a=base+k, mem_dout=byte k and mem_wr=1 in the cycle after Ek, k=0..N-1.
  - At E(N): mem_wr=0, mem_a=0, d_ready pulses one cycle, state returns to IDLE.
  - Each write byte takes exactly one cycle; there is no wait.
- Address arithmetic: base+k is modulo 2^32; no alignment check.
- Misaligned accesses are legal and are simply sequential bytes.
- flush=1, sampled at an edge:
  - READ (either owner): abort to IDLE, mem_wr=0, no ready pulse, partial data discarded.
  - WRITE or WAIT_IO: ignored. Stores reach the bus only after commit, so they always complete and pulse d_ready.
  - IDLE: no accept on that edge.
- Ready pulses are never asserted for an aborted transaction.
- i_ready and d_ready are never high in the same cycle.
- rdy_in low: all state, counters and outputs frozen, including mem_wr. A held write byte is re-presented, which is acceptable because the memory model is also paused. Resumes exactly where it stopped.
- Back-to-back: the earliest next accept is the edge after the ready-pulse cycle, so there is one IDLE cycle minimum between transactions.
- Starvation: no fairness guarantee for fetch. The LSB issues only finite requests, so fetch progresses.

Test Plan:
- Fetch alone: i_addr=0x100, mem model bytes 0x13,0x05,0x10,0x00 → mem_a 0x100..0x103 on consecutive cycles; i_ready one cycle at E5; i_data=0x00100513.
- Simultaneous i_req and d_req (load, d_len=2, addr 0x204, bytes 0xAA,0xBB) → data served first, d_rdata=0x0000BBAA; fetch starts on the edge after d_ready and completes normally.
- Store d_len=4, addr 0x300, d_wdata=0xDEADBEEF → mem_wr=1 for 4 cycles with mem_dout EF,BE,AD,DE at 0x300..0x303; d_ready at E4; mem_wr=0 after.
- IO store 0x30000, byte 0x41, io_buffer_full=1 for 3 cycles → mem_wr stays 0 through WAIT_IO; exactly one write of 0x41 after release; d_ready pulses once.
- flush at E2 of a fetch → no i_ready, state IDLE at E3, mem_wr=0; a new i_req at 0x400 then returns the correct word. The same flush during a store still completes the store.
- rdy_in low for 5 cycles mid-load and rst_in pulsed low mid-fetch → the load result matches the unpaused run, shifted by 5 cycles; reset immediately clears all outputs to reset values with no ready pulse.
